// File: rtl/maxnet_param.sv
// Parametrised MaxNet winner-take-all engine: latches N activations, applies
// lateral inhibition once per clock until at most one neuron stays nonzero.
module maxnet_param #(
   parameter int N         = 4,
   parameter int W         = 8,
   parameter int EPS_SHIFT = 2,
   parameter int MAX_ITER  = 31,
   parameter int IW        = $clog2(MAX_ITER + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [N*W-1:0]       in_vec,
   output logic                 done,
   output logic [W-1:0]         result,
   output logic [$clog2(N)-1:0] winner_idx,
   output logic                 no_winner,
   output logic                 timeout,
   output logic [IW-1:0]        iter_count,
   output logic                 busy
);

   localparam int XW = $clog2(N);
   localparam int SW = W + XW;
   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  a_q [N];
   logic [W-1:0]  a_d [N];
   logic [W-1:0]  result_q, result_d;
   logic [XW-1:0] idx_q, idx_d;
   logic          nowin_q, nowin_d;
   logic          tout_q, tout_d;
   logic [IW-1:0] iter_q, iter_d;

   logic [SW-1:0] sum;
   logic [SW-1:0] inh  [N];
   logic [W-1:0]  a_nx [N];
   logic [W-1:0]  ev   [N];
   logic [CW-1:0] nz_cnt;
   logic [XW-1:0] best_idx;
   logic [W-1:0]  best_val;
   logic [IW-1:0] iter_inc;
   logic          accept;

   always_comb begin
      sum = '0;
      for (int unsigned j = 0; j < N; j++) begin
         sum = sum + SW'(a_q[j]);
      end
      for (int unsigned j = 0; j < N; j++) begin
         inh[j]  = (sum - SW'(a_q[j])) >> EPS_SHIFT;
         a_nx[j] = (SW'(a_q[j]) > inh[j]) ? a_q[j] - inh[j][W-1:0] : '0;
      end
   end

   // One resolver serves both the freshly latched vector and the updated one.
   always_comb begin
      for (int unsigned j = 0; j < N; j++) begin
         ev[j] = (state_q == S_ITER) ? a_nx[j] : in_vec[j*W +: W];
      end
      nz_cnt   = '0;
      best_idx = '0;
      best_val = ev[0];
      for (int unsigned j = 0; j < N; j++) begin
         if (ev[j] != '0) begin
            nz_cnt = nz_cnt + CW'(1);
         end
         if (ev[j] > best_val) begin
            best_val = ev[j];
            best_idx = XW'(j);
         end
      end
   end

   assign accept   = start && (state_q != S_ITER);
   assign iter_inc = iter_q + IW'(1);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      result_d = result_q;
      idx_d    = idx_q;
      nowin_d  = nowin_q;
      tout_d   = tout_q;
      iter_d   = iter_q;
      if (accept) begin
         a_d      = ev;
         iter_d   = '0;
         result_d = '0;
         idx_d    = '0;
         nowin_d  = 1'b0;
         tout_d   = 1'b0;
         if (nz_cnt <= CW'(1)) begin
            state_d  = S_DONE;
            result_d = best_val;
            idx_d    = best_idx;
            nowin_d  = (nz_cnt == '0);
         end else begin
            state_d = S_ITER;
         end
      end else if (state_q == S_ITER) begin
         a_d    = a_nx;
         iter_d = iter_inc;
         if (nz_cnt <= CW'(1)) begin
            state_d  = S_DONE;
            result_d = best_val;
            idx_d    = best_idx;
            nowin_d  = (nz_cnt == '0);
         end else if (iter_inc == IW'(MAX_ITER)) begin
            state_d  = S_DONE;
            result_d = best_val;
            idx_d    = best_idx;
            tout_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         for (int unsigned j = 0; j < N; j++) begin
            a_q[j] <= '0;
         end
         result_q <= '0;
         idx_q    <= '0;
         nowin_q  <= 1'b0;
         tout_q   <= 1'b0;
         iter_q   <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         nowin_q  <= nowin_d;
         tout_q   <= tout_d;
         iter_q   <= iter_d;
      end
   end

   assign done       = (state_q == S_DONE);
   assign busy       = (state_q == S_ITER);
   assign result     = result_q;
   assign winner_idx = idx_q;
   assign no_winner  = nowin_q;
   assign timeout    = tout_q;
   assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_param.sv
// Directed bench for maxnet_param: a whole-run arithmetic model predicts each
// run's outcome and latency; a negedge monitor checks every output each cycle.
module tb_maxnet_param;

   localparam int N        = 4;
   localparam int W        = 8;
   localparam int EPS      = 2;
   localparam int MAX_ITER = 31;
   localparam int IW       = $clog2(MAX_ITER + 1);

   typedef int unsigned vec_t [N];

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [N*W-1:0]       in_vec;
   logic                 done;
   logic [W-1:0]         result;
   logic [$clog2(N)-1:0] winner_idx;
   logic                 no_winner;
   logic                 timeout;
   logic [IW-1:0]        iter_count;
   logic                 busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // expected outcome of the current run; m_valid=0 means reset-state outputs
   int m_valid = 0;
   int m_t0, m_k, m_res, m_idx, m_nw, m_to;

   maxnet_param #(
      .N(N), .W(W), .EPS_SHIFT(EPS), .MAX_ITER(MAX_ITER), .IW(IW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
      .done(done), .result(result), .winner_idx(winner_idx),
      .no_winner(no_winner), .timeout(timeout),
      .iter_count(iter_count), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Runs the whole winner-take-all process on plain integers.
   function automatic void model_run(input vec_t v, output int k, output int res,
                                     output int idx, output int nw, output int to);
      int unsigned a [N];
      int unsigned nx [N];
      int unsigned s, inh;
      int nz;
      a = v;
      k = 0;
      forever begin
         nz = 0;
         foreach (a[j]) if (a[j] != 0) nz++;
         if (nz <= 1 || k == MAX_ITER) break;
         s = 0;
         foreach (a[j]) s += a[j];
         foreach (a[j]) begin
            inh   = (s - a[j]) / (1 << EPS);
            nx[j] = (a[j] > inh) ? a[j] - inh : 0;
         end
         a = nx;
         k++;
      end
      res = 0; idx = 0;
      foreach (a[j]) if (a[j] > res) begin res = int'(a[j]); idx = j; end
      nw = (nz == 0) ? 1 : 0;
      to = (nz > 1) ? 1 : 0;
   endfunction

   always @(negedge clk) begin
      int c;
      if (rst || m_valid == 0) begin
         check("rst_done", int'(done), 0);
         check("rst_busy", int'(busy), 0);
         check("rst_result", int'(result), 0);
         check("rst_idx", int'(winner_idx), 0);
         check("rst_nowin", int'(no_winner), 0);
         check("rst_tout", int'(timeout), 0);
         check("rst_iter", int'(iter_count), 0);
      end else begin
         c = cyc - m_t0;
         if (c >= m_k) begin
            check("done", int'(done), 1);
            check("busy", int'(busy), 0);
            check("result", int'(result), m_res);
            check("winner_idx", int'(winner_idx), m_idx);
            check("no_winner", int'(no_winner), m_nw);
            check("timeout", int'(timeout), m_to);
            check("iter_count", int'(iter_count), m_k);
         end else begin
            check("run_done", int'(done), 0);
            check("run_busy", int'(busy), 1);
            check("run_result", int'(result), 0);
            check("run_idx", int'(winner_idx), 0);
            check("run_flags", int'({no_winner, timeout}), 0);
            check("run_iter", int'(iter_count), c);
         end
      end
   end

   // Presents v with start, holds start for 'hold' extra edges, then scrambles
   // in_vec to show it is only sampled on the accepting edge.
   task automatic run_vec(input vec_t v, input int hold);
      int k, res, idx, nw, to;
      @(negedge clk);
      for (int j = 0; j < N; j++) in_vec[j*W +: W] = v[j][W-1:0];
      start = 1'b1;
      @(posedge clk);
      #1;
      model_run(v, k, res, idx, nw, to);
      m_t0 = cyc; m_k = k; m_res = res; m_idx = idx; m_nw = nw; m_to = to;
      m_valid = 1;
      in_vec = {$urandom, $urandom};
      repeat (hold) @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done();
      int seen;
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("wait_done_bound", seen, 1);
      #1;
   endtask

   task automatic pin(input string tag, input int res, input int idx,
                      input int it, input int nw, input int to);
      check({tag, "_result"}, int'(result), res);
      check({tag, "_idx"}, int'(winner_idx), idx);
      check({tag, "_iter"}, int'(iter_count), it);
      check({tag, "_nowin"}, int'(no_winner), nw);
      check({tag, "_tout"}, int'(timeout), to);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int k, res, idx, nw, to;
      rst = 1'b1; start = 1'b0; in_vec = '0;

      model_run('{20, 40, 60, 80}, k, res, idx, nw, to);
      check("model_base_k", k, 4);
      check("model_base_res", res, 41);
      check("model_base_idx", idx, 3);
      model_run('{50, 50, 0, 0}, k, res, idx, nw, to);
      check("model_tie_k", k, 31);
      check("model_tie_res", res, 3);
      check("model_tie_to", to, 1);

      repeat (3) @(negedge clk);
      rst = 1'b0;

      run_vec('{20, 40, 60, 80}, 0);
      wait_done();
      pin("base", 41, 3, 4, 0, 0);

      run_vec('{80, 60, 40, 20}, 3);
      check("restart_done_drop", int'(done), 0);
      wait_done();
      pin("restart", 41, 0, 4, 0, 0);

      run_vec('{50, 50, 0, 0}, 0);
      wait_done();
      pin("tie", 3, 0, 31, 0, 1);

      run_vec('{0, 0, 99, 0}, 0);
      check("resolved_busy", int'(busy), 0);
      wait_done();
      pin("resolved", 99, 2, 0, 0, 0);

      run_vec('{0, 0, 0, 0}, 0);
      wait_done();
      pin("zero", 0, 0, 0, 1, 0);

      run_vec('{20, 40, 60, 80}, 0);
      repeat (3) @(negedge clk);
      check("midrun_iter", int'(iter_count), 2);
      #2 rst = 1'b1;
      m_valid = 0;
      #1;
      check("async_rst_outs", int'({done, busy, result, winner_idx, no_winner, timeout, iter_count}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_vec('{10, 0, 0, 0}, 0);
      wait_done();
      pin("after_rst", 10, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/maxnet_param.md
# maxnet_param

Parametrised winner-take-all (MaxNet) engine: N unsigned activations, lateral inhibition with epsilon = 2^-EPS_SHIFT, one full-parallel update per clock until at most one activation is nonzero. It is the generalised successor to the fixed 4-neuron maxnet. It adds configurable neuron count and width, an iteration cap with a timeout flag, a no-winner flag, and an iteration count output. It sits behind the classifier front end, which supplies the activation vector and a start pulse.

## Interface
- N, 4, number of neurons (>= 2)
- W, 8, activation width in bits (unsigned)
- EPS_SHIFT, 2, inhibition weight is 2^-EPS_SHIFT
- MAX_ITER, 31, iteration cap (>= 1)
- IW, $clog2(MAX_ITER+1), width of iter_count
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  level-sampled request; only acted on in IDLE or DONE
- in_vec  input  N*W  activations; neuron j at in_vec[j*W +: W]
- done  output  1  result valid; held until next accepted start
- result  output  W  winning activation value
- winner_idx  output  $clog2(N)  index of winning neuron
- no_winner  output  1  all activations reached zero
- timeout  output  1  MAX_ITER reached with more than one nonzero
- iter_count  output  IW  number of update iterations performed
- busy  output  1  high in ITER

## Operation
- States:
  - IDLE: reset state.
  - ITER: updates in progress.
  - DONE: outputs held.
- IDLE/DONE with start=1 at an edge: latch in_vec into internal a[0..N-1], clear flags, set iter_count=0, set done=0.
  - If latched vector has <= 1 nonzero, go directly to DONE.
  - Otherwise go to ITER.
- ITER, each edge:
  - S = sum of all a (width W+$clog2(N), no overflow).
  - inh_j = (S - a_j) >> EPS_SHIFT.
  - a_j' = (a_j > inh_j) ? a_j - inh_j : 0. Floor shift; saturate at 0; no wrap.
  - All N neurons update simultaneously from old values.
  - iter_count increments by 1.
- Termination is evaluated on the updated values a' in the same edge:
  - Exactly one nonzero: DONE; winner_idx = its index; result = its value.
  - Zero nonzero: DONE; no_winner=1, result=0, winner_idx=0.
  - More than one nonzero and iter_count' == MAX_ITER: DONE; timeout=1.
    - winner_idx = argmax of a'; ties go to the lowest index.
    - result = that value.
  - Otherwise stay in ITER.
- start in ITER is ignored. in_vec is only sampled at the accepting edge.
- The DONE → new run transition on start needs no return to IDLE.
- Asynchronous rst at any time: state=IDLE; all a=0. Outputs: done=0, busy=0, result=0, winner_idx=0, no_winner=0, timeout=0, iter_count=0.

## Timing
- Accepting edge E0: if the input is already resolved, done=1 right after E0 with iter_count=0.
- Otherwise, one edge per iteration. After the k-th ITER edge (E0+k) that meets termination, done=1 and busy=0, with iter_count=k.
- Worst-case latency from E0 to done: MAX_ITER edges.
- busy=1 from after E0 until the terminating edge.
- All outputs are registered. result/winner_idx/flags change only at the terminating edge or at an accepting edge (cleared there).
- Flags are mutually exclusive: at most one of no_winner and timeout is set.

## Test plan
- Defaults (N=4, W=8, EPS_SHIFT=2, MAX_ITER=31), in_vec={a0..a3}={20,40,60,80}, 1-cycle start.
  - Per-iteration a' values: {0,0,25,50}, {0,0,13,44}, {0,0,2,41}, {0,0,0,41}.
  - Required: done after 4th ITER edge; winner_idx=3, result=41, iter_count=4, flags 0.
- Tie {50,50,0,0}.
  - Both neurons decay equally and stall at 3.
  - Required: timeout=1 after 31 iterations; winner_idx=0, result=3, iter_count=31.
- Already resolved: {0,0,99,0} → done right after E0; winner_idx=2, result=99, iter_count=0, busy never high.
- All zero {0,0,0,0} → done after E0; no_winner=1, result=0, iter_count=0.
- Reset mid-run.
  - Start {20,40,60,80}, assert rst after 2 iterations.
  - Required: all outputs 0 immediately (asynchronous), state IDLE.
  - Next start with {10,0,0,0} → winner_idx=0, result=10.
- Restart from DONE and start held high.
  - After the first run completes, change in_vec to {80,60,40,20} and pulse start.
  - Required: done drops after the accepting edge; re-done with winner_idx=0, result=41, iter_count=4.
  - start held high for 3 cycles during ITER has no effect.
